// File: rtl/tt_div_pkg.sv
// +-----------------------------------------------------------------+
// | tt_div_pkg : shared types and sizes for the 8/4 divider         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

package tt_div_pkg;

  localparam int DVD_W = 8;
  localparam int DVR_W = 4;
  localparam int ITER  = 8;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [DVD_W-1:0] DIV0_QUOT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : tt_div_pkg

`default_nettype wire

// File: rtl/tt_div_step.sv
// +-----------------------------------------------------------------+
// | tt_div_step : one restoring subtract-and-shift iteration        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tt_div_step
  import tt_div_pkg::*;
(
  input  logic [DVR_W-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [DVR_W-1:0] divisor,
  output logic [DVR_W-1:0] rem_next,
  output logic             q_bit
);

  logic [DVR_W:0] partial;
  logic [DVR_W:0] diff;

  assign partial = {rem_in, dvd_bit};
  assign diff    = partial - {1'b0, divisor};

  // The restored remainder is always below the divisor, so it fits DVR_W bits.
  always_comb begin
    q_bit    = (partial >= {1'b0, divisor});
    rem_next = q_bit ? DVR_W'(diff) : DVR_W'(partial);
  end

endmodule : tt_div_step

`default_nettype wire

// File: rtl/tt_um_my_divider.sv
// +-----------------------------------------------------------------+
// | tt_um_my_divider : unsigned 8-bit / 4-bit sequential divider    |
// | Option macro TT_DIV_REMAINDER_EN adds a remainder view on uo_out|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tt_um_my_divider
  import tt_div_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic             start;
  logic [DVR_W-1:0] divisor_in;

  state_t state;
  state_t state_next;

  logic accept;
  logic div0;
  logic step_en;
  logic finish;

  logic [DVD_W-1:0] dvd_shift;
  logic [DVR_W-1:0] dvr_reg;
  logic [DVR_W-1:0] rem_work;
  logic [DVD_W-1:0] quot_work;
  logic [CNT_W-1:0] count;
  logic [DVD_W-1:0] quot_hold;
  logic             done;
  logic             err;

  logic [DVR_W-1:0] step_rem;
  logic             step_q;
  logic [DVD_W-1:0] quot_next;

  assign start      = uio_in[4];
  assign divisor_in = uio_in[3:0];

  tt_div_step u_step (
    .rem_in   (rem_work),
    .dvd_bit  (dvd_shift[DVD_W-1]),
    .divisor  (dvr_reg),
    .rem_next (step_rem),
    .q_bit    (step_q)
  );

  assign quot_next = {quot_work[DVD_W-2:0], step_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_next = (divisor_in == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (count == '0) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    accept  = 1'b0;
    div0    = 1'b0;
    step_en = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          div0   = (divisor_in == '0);
          accept = (divisor_in != '0);
        end
      end
      BUSY: begin
        step_en = 1'b1;
        finish  = (count == '0);
      end
      default: ;
    endcase
  end

  // quot_hold only changes on completion, so uo_out never shows partial work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd_shift <= '0;
      dvr_reg   <= '0;
      rem_work  <= '0;
      quot_work <= '0;
      count     <= '0;
      quot_hold <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      dvd_shift <= ui_in;
      dvr_reg   <= divisor_in;
      rem_work  <= '0;
      quot_work <= '0;
      count     <= CNT_W'(ITER - 1);
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (div0) begin
      rem_work  <= '0;
      quot_work <= DIV0_QUOT;
      quot_hold <= DIV0_QUOT;
      done      <= 1'b1;
      err       <= 1'b1;
    end else if (step_en) begin
      dvd_shift <= {dvd_shift[DVD_W-2:0], 1'b0};
      rem_work  <= step_rem;
      quot_work <= quot_next;
      count     <= count - CNT_W'(1);
      if (finish) begin
        quot_hold <= quot_next;
        done      <= 1'b1;
      end
    end
  end

`ifdef TT_DIV_REMAINDER_EN
  logic [DVR_W-1:0] rem_hold;
  logic             unused_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_hold <= '0;
    end else if (div0) begin
      rem_hold <= '0;
    end else if (step_en && finish) begin
      rem_hold <= step_rem;
    end
  end

  assign uo_out    = uio_in[5] ? {{(DVD_W-DVR_W){1'b0}}, rem_hold} : quot_hold;
  assign unused_ok = &{1'b0, ena, uio_in[7:6]};
`else
  logic unused_ok;

  assign uo_out    = quot_hold;
  assign unused_ok = &{1'b0, ena, uio_in[7:5]};
`endif

  assign uio_out = {err, done, 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

endmodule : tt_um_my_divider

`default_nettype wire

// File: tb/tb_tt_um_my_divider.sv
// +-----------------------------------------------------------------+
// | tb_tt_um_my_divider : directed-vector bench for the divider     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_tt_um_my_divider;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_my_divider dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_done, input logic exp_err);
    check({tag, "_done"}, {7'b0, uio_out[6]}, {7'b0, exp_done});
    check({tag, "_err"},  {7'b0, uio_out[7]}, {7'b0, exp_err});
  endtask

  task automatic check_rem(input string tag, input logic [7:0] exp);
`ifdef TT_DIV_REMAINDER_EN
    uio_in[5] = 1'b1;
    #1;
    check(tag, uo_out, exp);
    uio_in[5] = 1'b0;
    #1;
`else
    if (tag.len() < 0) $display("%s %0d", tag, exp);
`endif
  endtask

  // One-cycle start pulse: the capture edge is consumed here.
  task automatic launch(input logic [7:0] dvd, input logic [3:0] dvr);
    ui_in       = dvd;
    uio_in[3:0] = dvr;
    uio_in[4]   = 1'b1;
    tick();
    uio_in[4]   = 1'b0;
  endtask

  logic [7:0] tbl_dvd [4];
  logic [3:0] tbl_dvr [4];
  logic [7:0] tbl_q   [4];
  logic [7:0] tbl_r   [4];

  initial begin
    tbl_dvd = '{8'd255, 8'd8, 8'd0, 8'd254};
    tbl_dvr = '{4'd15,  4'd15, 4'd5, 4'd2};
    tbl_q   = '{8'd17,  8'd0,  8'd0, 8'd127};
    tbl_r   = '{8'd0,   8'd8,  8'd0, 8'd0};

    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    repeat (2) tick();
    check("rst_uo", uo_out, 8'h00);
    check_flags("rst", 1'b0, 1'b0);
    check("uio_oe", uio_oe, 8'hC0);
    check("uio_lo", {2'b00, uio_out[5:0]}, 8'h00);
    rst_n = 1'b1;
    tick();

    // 200 / 7 = 28 r 4, done on the ninth edge counted from the start pulse
    launch(8'd200, 4'd7);
    check("t1_busy_hold", uo_out, 8'h00);
    repeat (7) tick();
    check_flags("t1_early", 1'b0, 1'b0);
    check("t1_early_uo", uo_out, 8'h00);
    tick();
    check_flags("t1", 1'b1, 1'b0);
    check("t1_quot", uo_out, 8'h1C);
    check_rem("t1_rem", 8'h04);
    repeat (3) tick();
    check_flags("t1_held", 1'b1, 1'b0);
    check("t1_held_uo", uo_out, 8'h1C);

    // divide by zero finishes on the start edge
    launch(8'd13, 4'd0);
    check_flags("dz", 1'b1, 1'b1);
    check("dz_quot", uo_out, 8'hFF);
    check_rem("dz_rem", 8'h00);

    // 255 / 1 = 255 r 0; accepting start clears done and err
    launch(8'd255, 4'd1);
    check_flags("t2_start", 1'b0, 1'b0);
    check("t2_busy_hold", uo_out, 8'hFF);
    repeat (8) tick();
    check_flags("t2", 1'b1, 1'b0);
    check("t2_quot", uo_out, 8'hFF);
    check_rem("t2_rem", 8'h00);

    // second start (9/3) during BUSY is ignored
    launch(8'd200, 4'd7);
    repeat (2) tick();
    ui_in       = 8'd9;
    uio_in[3:0] = 4'd3;
    uio_in[4]   = 1'b1;
    tick();
    uio_in[4]   = 1'b0;
    repeat (5) tick();
    check_flags("t3", 1'b1, 1'b0);
    check("t3_quot", uo_out, 8'h1C);
    tick();
    check("t3_after", uo_out, 8'h1C);
    check_flags("t3_after", 1'b1, 1'b0);

    // reset in the middle of BUSY, then a fresh 100 / 9 = 11 r 1
    launch(8'd200, 4'd7);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    check("t4_rst_uo", uo_out, 8'h00);
    check_flags("t4_rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (9) tick();
    check_flags("t4_idle", 1'b0, 1'b0);
    check("t4_idle_uo", uo_out, 8'h00);
    launch(8'd100, 4'd9);
    repeat (8) tick();
    check_flags("t4", 1'b1, 1'b0);
    check("t4_quot", uo_out, 8'h0B);
    check_rem("t4_rem", 8'h01);

    // operands wiggle every cycle after capturing 50 / 4 = 12 r 2
    launch(8'd50, 4'd4);
    for (int i = 0; i < 8; i++) begin
      ui_in       = 8'(i * 29 + 3);
      uio_in[3:0] = 4'(i);
      tick();
    end
    check_flags("t5", 1'b1, 1'b0);
    check("t5_quot", uo_out, 8'h0C);
    check_rem("t5_rem", 8'h02);

    // boundary vectors: largest divisor, zero dividend, even split
    for (int k = 0; k < 4; k++) begin
      launch(tbl_dvd[k], tbl_dvr[k]);
      repeat (8) tick();
      check($sformatf("tbl%0d_quot", k), uo_out, tbl_q[k]);
      check_rem($sformatf("tbl%0d_rem", k), tbl_r[k]);
    end

    // start held high: each DONE is followed by an immediate recapture
    ui_in       = 8'd200;
    uio_in[3:0] = 4'd7;
    uio_in[4]   = 1'b1;
    tick();
    repeat (8) tick();
    check_flags("t6_first", 1'b1, 1'b0);
    check("t6_first_quot", uo_out, 8'h1C);
    tick();
    check_flags("t6_recap", 1'b0, 1'b0);
    repeat (8) tick();
    check_flags("t6_second", 1'b1, 1'b0);
    check("t6_second_quot", uo_out, 8'h1C);
    uio_in[4] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tt_um_my_divider

`default_nettype wire

// File: doc/tt_um_my_divider.md
TT_UM_MY_DIVIDER -- requirements
Module: tt_um_my_divider

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port ena, input, 1 bit: ignored; it has no functional effect.
REQ-004 SHALL have port ui_in, input, 8 bits: dividend.
REQ-005 SHALL have port uio_in, input, 8 bits:
- [3:0] divisor.
- [4] start.
- [5] result select (see REQ-023).
- [7:6] ignored.
REQ-006 SHALL have port uo_out, output, 8 bits: result (quotient, or remainder when selected).
REQ-007 SHALL have port uio_out, output, 8 bits:
- [6] done.
- [7] div-by-zero error.
- [5:0] tied to 0.
REQ-008 SHALL have port uio_oe, output, 8 bits: constant 8'b1100_0000.

Function
REQ-009 SHALL compute an unsigned 8-bit / 4-bit restoring division:
- quotient: 8 bits.
- remainder: 4 bits, always less than the divisor.
REQ-010 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-011 SHALL, in IDLE or DONE, on a clock edge with start=1 and divisor!=0:
- capture the dividend and divisor;
- clear done and err;
- load the iteration counter with 7;
- enter BUSY.
REQ-012 SHALL, on each clock edge in BUSY:
- shift the next dividend bit (MSB first) into a 5-bit partial remainder;
- subtract the divisor when the partial remainder is greater than or equal to it;
- shift the resulting quotient bit in;
- decrement the counter.
REQ-013 SHALL leave BUSY after exactly 8 BUSY edges, enter DONE, and set done=1; done is first visible 9 cycles after the start edge.
REQ-014 SHALL, on a start edge with divisor==0, skip BUSY and enter DONE on that same edge with:
- quotient=8'hFF;
- remainder=4'h0;
- err=1;
- done=1.
REQ-015 SHALL ignore start while in BUSY.
REQ-016 SHALL ignore changes to ui_in and uio_in[3:0] after the capture edge.
REQ-017 SHALL hold the DONE results and done=1 until the next accepted start or reset.
REQ-018 SHALL hold uo_out at its previous value during BUSY; intermediate values never appear on it.
REQ-019 SHALL accept start held high continuously: each entry into DONE is followed on the next edge by a new capture.

Reset
REQ-020 SHALL, on a clock edge with rst_n=0, force:
- state to IDLE;
- quotient and remainder to 0;
- uo_out to 8'h00;
- done and err to 0;
- counter to 0.
REQ-021 SHALL abort any BUSY operation on reset with no partial result retained.
REQ-022 SHALL ignore start on any edge where rst_n=0.

Configuration
REQ-023 SHALL support macro TT_DIV_REMAINDER_EN with the following behaviour:
- defined: uio_in[5]=1 drives uo_out={4'h0, remainder}; uio_in[5]=0 drives the quotient. The select is combinational and applies in every state.
- undefined: uio_in[5] is ignored, uo_out always shows the quotient, and no remainder output register exists.

Structure
REQ-024 SHALL take the following from a shared package tt_div_pkg:
- state enum (IDLE, BUSY, DONE);
- DVD_W=8, DVR_W=4, ITER=8;
- constant DIV0_QUOT=8'hFF.
REQ-025 SHALL place one subtract-and-shift step in sub-module tt_div_step, instantiated once in the top.

Verification
REQ-026 SHALL cover: dividend 200 (8'hC8), divisor 7, start pulse -> done=1 exactly 9 cycles later, uo_out=8'h1C, err=0.
REQ-027 SHALL cover: dividend 255, divisor 1 -> quotient 8'hFF; with macro and select=1, uo_out=8'h00.
REQ-028 SHALL cover: dividend 13, divisor 0 -> the next cycle shows done=1, err=1, uo_out=8'hFF.
REQ-029 SHALL cover: start 200/7, re-pulse start with 9/3 at cycle 4 -> the result is still 8'h1C at cycle 9, and the second request is ignored.
REQ-030 SHALL cover: rst_n=0 at cycle 5 of a BUSY operation -> the next cycle shows done=0, err=0, uo_out=8'h00; a fresh 100/9 then yields 8'h0B, remainder 1.
REQ-031 SHALL cover: operands changed on every cycle after capture of 50/4 -> result 8'h0C, remainder 2.
